// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencer: FSM states, the
// step-table entry layout and the timer control-word bit positions.
package timer_seq_pkg;

    // Timer control word layout (bits not listed here are always driven 0).
    localparam int CTRL_W       = 9;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_SINGLE  = 4;
    localparam int CTRL_INTE    = 5;
    localparam int CTRL_CNTRRST = 7;

    // Widest repeat count an entry can hold; narrower RPT_W values zero-extend.
    localparam int RPT_MAX_W = 32;

    // Control word while parked: counter held in reset, everything else off.
    localparam logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(1) << CTRL_CNTRRST;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [31:0]          hrc;
        logic [31:0]          lrc;
        logic [RPT_MAX_W-1:0] rpt;
    } step_t;

    // Control word while counting: free-running (not single-shot), optional interrupt.
    function automatic logic [CTRL_W-1:0] run_ctrl(input logic inte);
        logic [CTRL_W-1:0] w;
        w               = '0;
        w[CTRL_EN]      = 1'b1;
        w[CTRL_SINGLE]  = 1'b0;
        w[CTRL_INTE]    = inte;
        return w;
    endfunction

endpackage

// File: rtl/timer_seq_table.sv
// Step table: register file of step_t entries, one synchronous write port and
// one asynchronous read port. Contents survive reset so software need not
// reprogram the table after a controller reset.
module timer_seq_table
    import timer_seq_pkg::*;
#(
    parameter int N_STEPS = 4
) (
    input  logic                       i_clk,
    input  logic                       we,
    input  logic [$clog2(N_STEPS)-1:0] waddr,
    input  step_t                      wdata,
    input  logic [$clog2(N_STEPS)-1:0] raddr,
    output step_t                      rdata
);

    step_t mem [N_STEPS];

    // Write port. NOTE: storage arrays carry no reset; that keeps them mappable
    // to plain flops/RAM and lets the table outlive a controller reset.
    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/timer_seq_ctrl.sv
// Timer sequencer: walks a table of {hrc, lrc, repeat} steps, reprogramming an
// external timer's reference registers on the exact edge each period restarts.
module timer_seq_ctrl
    import timer_seq_pkg::*;
#(
    parameter int N_STEPS = 4,
    parameter int RPT_W   = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       cfg_we,
    input  logic [$clog2(N_STEPS)-1:0] cfg_idx,
    input  logic [31:0]                cfg_hrc,
    input  logic [31:0]                cfg_lrc,
    input  logic [RPT_W-1:0]           cfg_rpt,
    input  logic [$clog2(N_STEPS):0]   num_steps,
    input  logic [31:0]                start_ofs,
    input  logic                       loop_en,
    input  logic                       int_en,
    input  logic                       start,
    input  logic                       abort,
    input  logic [31:0]                timer_cntr_Reg,
    output logic [31:0]                timer_hrc_Reg,
    output logic [31:0]                timer_lrc_Reg,
    output logic [CTRL_W-1:0]          timer_ctrl_Reg,
    output logic                       timer_cntr_Reg_sel,
    output logic [31:0]                wb_data_reg_out,
    output logic                       busy,
    output logic [$clog2(N_STEPS)-1:0] step_idx,
    output logic                       done
);

    localparam int IDX_W = $clog2(N_STEPS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(N_STEPS);

    seq_state_e         state;
    logic [RPT_W-1:0]   rpt_cnt;
    logic [31:0]        cur_rpt;
    step_t              wr_entry;
    step_t              rd_entry;
    logic [IDX_W-1:0]   rd_addr;
    logic [CNT_W-1:0]   step_plus1;
    logic               num_ok;
    logic               last_step;
    logic               period_end;
    logic               rpt_done;

    assign wr_entry = '{hrc: cfg_hrc, lrc: cfg_lrc, rpt: RPT_MAX_W'(cfg_rpt)};

    timer_seq_table #(.N_STEPS(N_STEPS)) u_table (
        .i_clk (i_clk),
        .we    (cfg_we),
        .waddr (cfg_idx),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    assign num_ok     = (num_steps != '0) && (num_steps <= NUM_MAX);
    assign step_plus1 = CNT_W'(step_idx) + CNT_W'(1);
    assign last_step  = step_plus1 >= num_steps;
    assign period_end = timer_ctrl_Reg[CTRL_EN] && (timer_cntr_Reg == timer_lrc_Reg);
    assign rpt_done   = 32'(rpt_cnt) >= cur_rpt;

    // The single read port always points at the entry to load on the next switch.
    assign rd_addr = (state == ST_RUN && !last_step) ? step_idx + IDX_W'(1) : '0;

    // Sequencer FSM; every output is registered so reference switches land on
    // the same edge the timer restarts. NOTE: all state here updates with <=
    // so every branch sees pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= ST_IDLE;
            timer_ctrl_Reg     <= CTRL_IDLE;
            timer_hrc_Reg      <= '0;
            timer_lrc_Reg      <= '0;
            wb_data_reg_out    <= '0;
            timer_cntr_Reg_sel <= 1'b0;
            step_idx           <= '0;
            rpt_cnt            <= '0;
            cur_rpt            <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            timer_cntr_Reg_sel <= 1'b0;
            done               <= 1'b0;
            if (abort) begin
                state          <= ST_IDLE;
                timer_ctrl_Reg <= CTRL_IDLE;
                busy           <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        timer_ctrl_Reg <= CTRL_IDLE;
                        busy           <= 1'b0;
                        if (start && num_ok) begin
                            timer_hrc_Reg      <= rd_entry.hrc;
                            timer_lrc_Reg      <= rd_entry.lrc;
                            cur_rpt            <= rd_entry.rpt;
                            step_idx           <= '0;
                            rpt_cnt            <= '0;
                            wb_data_reg_out    <= start_ofs;
                            timer_cntr_Reg_sel <= 1'b1;
                            timer_ctrl_Reg     <= '0;
                            busy               <= 1'b1;
                            state              <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        timer_ctrl_Reg <= run_ctrl(int_en);
                        state          <= ST_RUN;
                    end
                    ST_RUN: begin
                        timer_ctrl_Reg <= run_ctrl(int_en);
                        if (period_end) begin
                            if (!rpt_done) begin
                                rpt_cnt <= rpt_cnt + RPT_W'(1);
                            end else if (!last_step || loop_en) begin
                                timer_hrc_Reg <= rd_entry.hrc;
                                timer_lrc_Reg <= rd_entry.lrc;
                                cur_rpt       <= rd_entry.rpt;
                                step_idx      <= rd_addr;
                                rpt_cnt       <= '0;
                            end else begin
                                timer_ctrl_Reg <= CTRL_IDLE;
                                busy           <= 1'b0;
                                done           <= 1'b1;
                                state          <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        timer_ctrl_Reg <= CTRL_IDLE;
                        state          <= ST_IDLE;
                    end
                    default: begin
                        timer_ctrl_Reg <= CTRL_IDLE;
                        busy           <= 1'b0;
                        state          <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Bench for timer_seq_ctrl: a bench-side timer closes the loop, a period-level
// reference model predicts every output each cycle, and directed scenarios pin
// cycle counts with hand-derived literals before a randomized soak.
module tb_timer_seq_ctrl;

    localparam int NS = 4;
    localparam int RW = 4;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_hrc, cfg_lrc;
    logic [RW-1:0] cfg_rpt;
    logic [2:0]  num_steps;
    logic [31:0] start_ofs;
    logic        loop_en, int_en, start, abort;
    logic [31:0] cntr = '0;
    logic [31:0] timer_hrc_Reg, timer_lrc_Reg, wb_data_reg_out;
    logic [8:0]  timer_ctrl_Reg;
    logic        timer_cntr_Reg_sel, busy, done;
    logic [1:0]  step_idx;

    always #5 clk = ~clk;

    timer_seq_ctrl #(.N_STEPS(NS), .RPT_W(RW)) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .cfg_we             (cfg_we),
        .cfg_idx            (cfg_idx),
        .cfg_hrc            (cfg_hrc),
        .cfg_lrc            (cfg_lrc),
        .cfg_rpt            (cfg_rpt),
        .num_steps          (num_steps),
        .start_ofs          (start_ofs),
        .loop_en            (loop_en),
        .int_en             (int_en),
        .start              (start),
        .abort              (abort),
        .timer_cntr_Reg     (cntr),
        .timer_hrc_Reg      (timer_hrc_Reg),
        .timer_lrc_Reg      (timer_lrc_Reg),
        .timer_ctrl_Reg     (timer_ctrl_Reg),
        .timer_cntr_Reg_sel (timer_cntr_Reg_sel),
        .wb_data_reg_out    (wb_data_reg_out),
        .busy               (busy),
        .step_idx           (step_idx),
        .done               (done)
    );

    // Bench-side timer: load strobe, then counter reset (bit 7), then count when EN (bit 0).
    always @(posedge clk) begin
        if (timer_cntr_Reg_sel === 1'b1)      cntr <= wb_data_reg_out;
        else if (timer_ctrl_Reg[7] === 1'b1)  cntr <= '0;
        else if (timer_ctrl_Reg[0] === 1'b1)  cntr <= (cntr == timer_lrc_Reg) ? '0 : cntr + 1;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: table copy, expected outputs, periods left in the current step.
    int unsigned t_hrc [NS];
    int unsigned t_lrc [NS];
    int unsigned t_rpt [NS];
    logic [8:0]  e_ctrl;
    logic [31:0] e_hrc, e_lrc, e_wb;
    logic        e_sel, e_busy, e_done;
    int          e_step;
    bit          m_seq, m_loading;
    int          m_left;

    function automatic logic [127:0] pack(logic [8:0] c, logic s, logic b, logic d,
                                          logic [1:0] st, logic [31:0] h, logic [31:0] l,
                                          logic [31:0] w);
        return {18'd0, c, s, b, d, st, h, l, w};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] run_word();
        return 9'h001 | (int_en ? 9'h020 : 9'h000);
    endfunction

    task automatic load_entry(input int i);
        e_hrc  = t_hrc[i];
        e_lrc  = t_lrc[i];
        m_left = int'(t_rpt[i]) + 1;
    endtask

    // Predict outputs after the coming edge from the inputs now driven.
    task automatic model_step();
        bit was_done;
        bit pe;
        pe = e_ctrl[0] && (cntr == e_lrc);
        if (i_rst) begin
            e_ctrl = 9'h080; e_hrc = '0; e_lrc = '0; e_wb = '0; e_step = 0;
            e_sel = 1'b0; e_busy = 1'b0; e_done = 1'b0; m_seq = 1'b0; m_loading = 1'b0;
        end else begin
            was_done = e_done;
            e_sel  = 1'b0;
            e_done = 1'b0;
            if (abort) begin
                m_seq = 1'b0; m_loading = 1'b0; e_ctrl = 9'h080; e_busy = 1'b0;
            end else if (!m_seq) begin
                e_ctrl = 9'h080; e_busy = 1'b0;
                if (!was_done && start && num_steps >= 1 && num_steps <= NS) begin
                    load_entry(0);
                    e_step = 0; e_wb = start_ofs; e_sel = 1'b1; e_ctrl = '0;
                    e_busy = 1'b1; m_seq = 1'b1; m_loading = 1'b1;
                end
            end else if (m_loading) begin
                m_loading = 1'b0;
                e_ctrl = run_word();
            end else begin
                e_ctrl = run_word();
                if (pe) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (e_step + 1 < int'(num_steps)) begin
                            e_step++;
                            load_entry(e_step);
                        end else if (loop_en) begin
                            e_step = 0;
                            load_entry(0);
                        end else begin
                            m_seq = 1'b0; e_ctrl = 9'h080; e_busy = 1'b0; e_done = 1'b1;
                        end
                    end
                end
            end
        end
        if (cfg_we) begin
            t_hrc[cfg_idx] = cfg_hrc;
            t_lrc[cfg_idx] = cfg_lrc;
            t_rpt[cfg_idx] = cfg_rpt;
        end
    endtask

    // One clock: predict, let the edge happen, compare on the falling edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("cycle", pack(timer_ctrl_Reg, timer_cntr_Reg_sel, busy, done, step_idx,
                            timer_hrc_Reg, timer_lrc_Reg, wb_data_reg_out),
                       pack(e_ctrl, e_sel, e_busy, e_done, 2'(e_step), e_hrc, e_lrc, e_wb));
    endtask

    task automatic wr(input int idx, input int h, input int l, input int r);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_hrc = h; cfg_lrc = l; cfg_rpt = RW'(r);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_seq();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run cycles n0..max_n after a start and record events seen on the outputs.
    task automatic watch(input int n0, input int max_n, output int done_n, output int pe_cnt,
                         output int first_pe, output int sw_n, output int sw_cntr,
                         output int sw_prev);
        logic [31:0] prev_lrc, prev_cntr;
        done_n = 0; pe_cnt = 0; first_pe = 0; sw_n = 0; sw_cntr = -1; sw_prev = -1;
        prev_lrc = timer_lrc_Reg; prev_cntr = cntr;
        for (int n = n0; n <= max_n; n++) begin
            tick();
            if (done && done_n == 0) done_n = n;
            if (timer_ctrl_Reg[0] && cntr == timer_lrc_Reg) begin
                pe_cnt++;
                if (first_pe == 0) first_pe = n;
            end
            if (timer_lrc_Reg != prev_lrc && sw_n == 0) begin
                sw_n = n; sw_cntr = int'(cntr); sw_prev = int'(prev_cntr);
            end
            prev_lrc = timer_lrc_Reg; prev_cntr = cntr;
        end
    endtask

    initial begin
        int dn, pc, fp, sn, sc, sp;
        int trans [$];
        bit done_seen, found;
        logic [1:0] prev_step;

        i_rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_hrc = '0; cfg_lrc = '0; cfg_rpt = '0;
        num_steps = 3'd1; start_ofs = '0; loop_en = 1'b0; int_en = 1'b0; start = 1'b0; abort = 1'b0;
        e_ctrl = 9'h080; e_hrc = '0; e_lrc = '0; e_wb = '0; e_step = 0;
        e_sel = 1'b0; e_busy = 1'b0; e_done = 1'b0; m_seq = 1'b0; m_loading = 1'b0; m_left = 0;
        for (int i = 0; i < NS; i++) begin t_hrc[i] = 0; t_lrc[i] = 0; t_rpt[i] = 0; end

        tick(); tick();
        check("reset_state", pack(timer_ctrl_Reg, timer_cntr_Reg_sel, busy, done, step_idx,
                                  timer_hrc_Reg, timer_lrc_Reg, wb_data_reg_out),
                             pack(9'h080, 0, 0, 0, 0, 0, 0, 0));
        i_rst = 1'b0;
        for (int i = 0; i < NS; i++) wr(i, i + 1, i + 2, 0);

        // Single step, two periods of six counts.
        wr(0, 2, 5, 1);
        num_steps = 3'd1; loop_en = 1'b0;
        start_seq();
        watch(2, 20, dn, pc, fp, sn, sc, sp);
        check("one_step_done_cycle", 128'(dn), 128'(14));
        check("one_step_periods", 128'(pc), 128'(2));

        // Two steps: lrc switch lands on the counter wrap 5->0.
        wr(0, 2, 5, 0);
        wr(1, 1, 3, 2);
        num_steps = 3'd2;
        start_seq();
        watch(2, 26, dn, pc, fp, sn, sc, sp);
        check("two_step_done_cycle", 128'(dn), 128'(20));
        check("two_step_periods", 128'(pc), 128'(4));
        check("lrc_switch_at", {32'(sn), 32'(sc), 32'(sp)}, {32'd8, 32'd0, 32'd5});

        // Start while busy is ignored: same completion cycle.
        start_seq();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        watch(4, 26, dn, pc, fp, sn, sc, sp);
        check("start_busy_ignored", 128'(dn), 128'(20));

        // Looping: step index alternates, done never fires.
        loop_en = 1'b1;
        start_seq();
        trans.delete();
        done_seen = 1'b0;
        prev_step = step_idx;
        for (int n = 2; n <= 60; n++) begin
            tick();
            if (done) done_seen = 1'b1;
            if (step_idx != prev_step) trans.push_back(int'(step_idx));
            prev_step = step_idx;
        end
        check("loop_no_done", 128'(done_seen), 128'(0));
        check("loop_trans_count", 128'(trans.size() >= 4), 128'(1));
        if (trans.size() >= 4)
            check("loop_step_seq", {32'(trans[0]), 32'(trans[1]), 32'(trans[2]), 32'(trans[3])},
                                   {32'd1, 32'd0, 32'd1, 32'd0});

        // Abort coincident with a period end.
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (timer_ctrl_Reg[0] && cntr == timer_lrc_Reg) begin
                found = 1'b1;
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end else begin
                tick();
            end
        end
        check("abort_found_pe", 128'(found), 128'(1));
        check("abort_state", {119'd0, timer_ctrl_Reg}, {119'd0, 9'h080});
        check("abort_flags", {126'd0, done, busy}, 128'd0);
        loop_en = 1'b0;
        tick();

        // Counter preload: LOAD drives the offset, first period end two counts in.
        wr(0, 7, 5, 0);
        num_steps = 3'd1; start_ofs = 32'd4;
        start_seq();
        check("load_cycle", {86'd0, timer_ctrl_Reg, timer_cntr_Reg_sel, wb_data_reg_out},
                            {86'd0, 9'h000, 1'b1, 32'd4});
        watch(2, 8, dn, pc, fp, sn, sc, sp);
        check("preload_first_pe", 128'(fp), 128'(3));
        check("preload_done_cycle", 128'(dn), 128'(4));
        start_ofs = '0;

        // All-ones repeat count: 2^RW periods, no wrap.
        wr(0, 9, 0, (1 << RW) - 1);
        start_seq();
        watch(2, 25, dn, pc, fp, sn, sc, sp);
        check("rpt_max_periods", 128'(pc), 128'(16));
        check("rpt_max_done_cycle", 128'(dn), 128'(18));

        // Illegal step count is ignored.
        num_steps = 3'd0;
        start_seq();
        check("num0_ignored", {126'd0, busy, timer_cntr_Reg_sel}, 128'd0);
        num_steps = 3'd5;
        start_seq();
        check("num5_ignored", {126'd0, busy, timer_cntr_Reg_sel}, 128'd0);

        // Reset mid-run wins over everything.
        wr(0, 2, 5, 0);
        num_steps = 3'd2;
        start_seq();
        for (int n = 0; n < 5; n++) tick();
        i_rst = 1'b1;
        tick();
        check("reset_mid_run", pack(timer_ctrl_Reg, timer_cntr_Reg_sel, busy, done, step_idx,
                                    timer_hrc_Reg, timer_lrc_Reg, wb_data_reg_out),
                               pack(9'h080, 0, 0, 0, 0, 0, 0, 0));
        i_rst = 1'b0;
        tick();

        // Randomized soak against the model.
        for (int n = 0; n < 3000; n++) begin
            cfg_we  = ($urandom % 4) == 0;
            cfg_idx = 2'($urandom % NS);
            cfg_hrc = $urandom;
            cfg_lrc = $urandom_range(0, 5);
            cfg_rpt = (($urandom % 16) == 0) ? RW'((1 << RW) - 1) : RW'($urandom_range(0, 2));
            if (!m_seq) begin
                num_steps = 3'($urandom_range(0, 5));
                start_ofs = $urandom_range(0, t_lrc[0]);
            end
            loop_en = ($urandom % 3) == 0;
            int_en  = $urandom % 2;
            start   = ($urandom % 6) == 0;
            abort   = ($urandom % 80) == 0;
            i_rst   = ($urandom % 500) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
